// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use stall
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic [RA_W-1:0]   in_rs1_addr,
    input  logic [RA_W-1:0]   in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic [RA_W-1:0]   in_rd_addr,
    input  logic              in_rd_we,
    input  logic [RA_W-1:0]   exm_rd_addr,
    input  logic              exm_rd_we,
    input  logic              exm_is_load,
    input  logic [XLEN-1:0]   exm_rd_data,
    input  logic [RA_W-1:0]   mwb_rd_addr,
    input  logic              mwb_rd_we,
    input  logic [XLEN-1:0]   mwb_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   data_x,
    output logic [XLEN-1:0]   data_y,
    output logic [XLEN-1:0]   store_data,
    output logic [RA_W-1:0]   out_rd_addr,
    output logic              out_rd_we,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              v, use_pc, use_imm;
    logic [RA_W-1:0]   rs1_a, rs2_a;
    logic [XLEN-1:0]   rs1_d, rs2_d, imm, pc, fwd1, fwd2;
    logic              exm_hit1, exm_hit2, mwb_hit1, mwb_hit2, hazard, fire_out, load;
    always_comb begin
        exm_hit1  = exm_rd_we && exm_rd_addr == rs1_a && rs1_a != '0;
        exm_hit2  = exm_rd_we && exm_rd_addr == rs2_a && rs2_a != '0;
        mwb_hit1  = mwb_rd_we && mwb_rd_addr == rs1_a && rs1_a != '0;
        mwb_hit2  = mwb_rd_we && mwb_rd_addr == rs2_a && rs2_a != '0;
        fwd1      = exm_hit1 ? exm_rd_data : mwb_hit1 ? mwb_rd_data : rs1_d;
        fwd2      = exm_hit2 ? exm_rd_data : mwb_hit2 ? mwb_rd_data : rs2_d;
        data_x    = use_pc ? pc : fwd1;
        data_y    = use_imm ? imm : fwd2;
        store_data = fwd2;
        hazard    = v && exm_is_load && exm_rd_we && exm_rd_addr != '0 && ((exm_hit1 && !use_pc) || exm_hit2);
        out_valid = v && !hazard;
        fire_out  = out_valid && out_ready;
        in_ready  = !flush && (!v || fire_out);
        load      = in_valid && in_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v           <= 1'b0;
            alu_ctrl    <= '0;
            rs1_a       <= '0;
            rs2_a       <= '0;
            rs1_d       <= '0;
            rs2_d       <= '0;
            imm         <= '0;
            pc          <= '0;
            use_pc      <= 1'b0;
            use_imm     <= 1'b0;
            out_rd_addr <= '0;
            out_rd_we   <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (flush) v <= 1'b0;
            else if (load) begin
                v           <= 1'b1;
                alu_ctrl    <= in_alu_ctrl;
                rs1_a       <= in_rs1_addr;
                rs2_a       <= in_rs2_addr;
                rs1_d       <= in_rs1_data;
                rs2_d       <= in_rs2_data;
                imm         <= in_imm;
                pc          <= in_pc;
                use_pc      <= in_use_pc;
                use_imm     <= in_use_imm;
                out_rd_addr <= in_rd_addr;
                out_rd_we   <= in_rd_we;
            end else if (fire_out) v <= 1'b0;
            if (hazard && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]  in_alu_ctrl = '0, alu_ctrl;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0, exm_rd_addr = '0, mwb_rd_addr = '0, out_rd_addr;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0, in_pc = '0, exm_rd_data = '0, mwb_rd_data = '0;
    logic        in_use_pc = 1'b0, in_use_imm = 1'b0, in_rd_we = 1'b0;
    logic        exm_rd_we = 1'b0, exm_is_load = 1'b0, mwb_rd_we = 1'b0, out_valid, out_ready = 1'b1, out_rd_we;
    logic [31:0] data_x, data_y, store_data, stall_cnt;
    int checks = 0, failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_ctrl(in_alu_ctrl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_is_load(exm_is_load), .exm_rd_data(exm_rd_data),
        .mwb_rd_addr(mwb_rd_addr), .mwb_rd_we(mwb_rd_we), .mwb_rd_data(mwb_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .data_x(data_x), .data_y(data_y),
        .store_data(store_data), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] c, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] im,
                         input logic [31:0] p, input logic upc, input logic uim, input logic [4:0] rd);
        in_alu_ctrl = c; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
        in_imm = im; in_pc = p; in_use_pc = upc; in_use_imm = uim; in_rd_addr = rd; in_rd_we = 1'b1;
        in_valid = 1'b1;
    endtask

    initial begin
        instr(4'h0, 5'd5, 32'd7, 5'd6, 32'd9, 32'h0, 32'h100, 1'b0, 1'b0, 5'd10);
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_x", data_x, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_stall_cnt", stall_cnt, 32'd0);
        chk("rel_rd_we", 32'(out_rd_we), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("add_x", data_x, 32'd7);
        chk("add_y", data_y, 32'd9);
        chk("add_store", store_data, 32'd9);
        chk("add_rd", 32'(out_rd_addr), 32'd10);
        chk("add_rd_we", 32'(out_rd_we), 32'd1);
        tick();
        chk("add_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        instr(4'h3, 5'd3, 32'h11, 5'd6, 32'd9, 32'h0, 32'h104, 1'b0, 1'b0, 5'd11);
        tick();
        in_valid = 1'b0;
        exm_rd_addr = 5'd3; exm_rd_we = 1'b1; exm_rd_data = 32'hAA;
        mwb_rd_addr = 5'd3; mwb_rd_we = 1'b1; mwb_rd_data = 32'hBB;
        #1;
        chk("fwd_exm_wins", data_x, 32'hAA);
        chk("fwd_alu_ctrl", 32'(alu_ctrl), 32'd3);
        exm_rd_we = 1'b0;
        #1;
        chk("fwd_mwb", data_x, 32'hBB);
        exm_rd_addr = 5'd0; exm_rd_we = 1'b1; mwb_rd_addr = 5'd0;
        out_ready = 1'b1;
        instr(4'h1, 5'd0, 32'h0, 5'd0, 32'h22, 32'h0, 32'h108, 1'b0, 1'b0, 5'd12);
        #1;
        chk("thru_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("x0_x", data_x, 32'd0);
        chk("x0_y", data_y, 32'h22);
        chk("x0_out_valid", 32'(out_valid), 32'd1);

        exm_rd_addr = 5'd4; exm_rd_we = 1'b1; exm_is_load = 1'b1; exm_rd_data = 32'h99;
        mwb_rd_we = 1'b0;
        instr(4'h0, 5'd7, 32'h70, 5'd4, 32'h1, 32'h0, 32'h10C, 1'b0, 1'b0, 5'd13);
        tick();
        in_valid = 1'b0;
        chk("lu_out_valid", 32'(out_valid), 32'd0);
        chk("lu_in_ready", 32'(in_ready), 32'd0);
        chk("lu_stall_pre", stall_cnt, 32'd0);
        tick();
        chk("lu_stall_post", stall_cnt, 32'd1);
        exm_rd_we = 1'b0; exm_is_load = 1'b0;
        mwb_rd_addr = 5'd4; mwb_rd_we = 1'b1; mwb_rd_data = 32'h55;
        #1;
        chk("lu_y_mwb", data_y, 32'h55);
        chk("lu_x", data_x, 32'h70);
        chk("lu_resume", 32'(out_valid), 32'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_x", data_x, 32'h70);
            chk("bp_y", data_y, 32'h55);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        flush = 1'b1;
        instr(4'h5, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 32'h200, 1'b0, 1'b0, 5'd14);
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("fl_not_taken", 32'(out_valid), 32'd0);
        chk("fl_stall", stall_cnt, 32'd1);

        out_ready = 1'b1; mwb_rd_we = 1'b0;
        instr(4'h2, 5'd9, 32'h90, 5'd8, 32'h3, 32'hFFFFFFFC, 32'h1000, 1'b0, 1'b1, 5'd15);
        tick();
        in_valid = 1'b0;
        exm_rd_addr = 5'd8; exm_rd_we = 1'b1; exm_is_load = 1'b1; exm_rd_data = 32'h77;
        #1;
        chk("imm_stall", 32'(out_valid), 32'd0);
        chk("imm_y", data_y, 32'hFFFFFFFC);
        chk("imm_store", store_data, 32'h77);
        tick();
        chk("imm_stall_cnt", stall_cnt, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_no_count", stall_cnt, 32'd2);
        chk("fl_killed", 32'(out_valid), 32'd0);
        instr(4'h0, 5'd8, 32'h80, 5'd5, 32'h50, 32'h0, 32'h1000, 1'b1, 1'b0, 5'd16);
        tick();
        in_valid = 1'b0;
        chk("pc_no_stall", 32'(out_valid), 32'd1);
        chk("pc_x", data_x, 32'h1000);
        chk("pc_y", data_y, 32'h50);

        out_ready = 1'b0;
        exm_rd_we = 1'b0; exm_is_load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_x", data_x, 32'd0);
        chk("async_stall", stall_cnt, 32'd0);
        chk("async_rd_we", 32'(out_rd_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
